// File: rtl/cv32e40x_pkg.sv
// rtl/cv32e40x_pkg.sv - Core PMA region configuration type shared with the testbench responder.
package cv32e40x_pkg;

  typedef struct packed {
    logic [31:0] word_addr_low;
    logic [31:0] word_addr_high;
    logic        main;
    logic        bufferable;
    logic        cacheable;
    logic        atomic;
  } pma_cfg_t;

endpackage

// File: rtl/uvmt_cv32e40x_pma_resp_pkg.sv
// rtl/uvmt_cv32e40x_pma_resp_pkg.sv - Response entry type, memtype rule and stall LFSR constants.
package uvmt_cv32e40x_pma_resp_pkg;
  import cv32e40x_pkg::*;

  localparam int          RESP_AGE_W = 8;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Taps 16,14,13,11 map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef struct packed {
    logic                  we;
    logic                  err;
    logic [31:0]           rdata;
    logic [RESP_AGE_W-1:0] age;
  } resp_entry_t;

  function automatic logic [1:0] exp_memtype(input pma_cfg_t cfg, input logic we, input logic atomic);
    return {cfg.cacheable, cfg.bufferable && we && !atomic};
  endfunction

endpackage

// File: rtl/uvmt_cv32e40x_pma_region_lookup.sv
// rtl/uvmt_cv32e40x_pma_region_lookup.sv - First-match PMA region lookup with debug-module override.
module uvmt_cv32e40x_pma_region_lookup
  import cv32e40x_pkg::*;
#(
  parameter int                PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t [15:0]   PMA_CFG         = '0,
  parameter logic [31:0]       DM_REGION_START = 32'h1A11_0800,
  parameter logic [31:0]       DM_REGION_END   = 32'h1A11_0FFF
) (
  input  logic [31:0] addr_i,
  input  logic        dbg_i,
  output pma_cfg_t    cfg_o,
  output logic        override_dm_o
);

  logic        matched;
  logic [33:0] addr_ext;

  assign addr_ext = {2'b00, addr_i};

  always_comb begin
    cfg_o         = '0;
    cfg_o.main    = (PMA_NUM_REGIONS == 0);
    matched       = 1'b0;
    override_dm_o = dbg_i && (addr_i >= DM_REGION_START) && (addr_i <= DM_REGION_END);
    for (int i = 0; i < 16; i++) begin
      if ((i < PMA_NUM_REGIONS) && !matched &&
          (addr_ext >= {PMA_CFG[i].word_addr_low, 2'b00}) &&
          (addr_ext <  {PMA_CFG[i].word_addr_high, 2'b00})) begin
        cfg_o   = PMA_CFG[i];
        matched = 1'b1;
      end
    end
    // Debug accesses to the DM window behave as plain main memory.
    if (override_dm_o) begin
      cfg_o      = '0;
      cfg_o.main = 1'b1;
    end
  end

endmodule

// File: rtl/uvmt_cv32e40x_pma_obi_responder.sv
// rtl/uvmt_cv32e40x_pma_obi_responder.sv - OBI data responder with PMA attribute checking and fixed-latency in-order responses.
// Optional random grant stalls: UVMT_CV32E40X_PMA_RESP_RANDOM_STALL_EN.
module uvmt_cv32e40x_pma_obi_responder
  import cv32e40x_pkg::*;
  import uvmt_cv32e40x_pma_resp_pkg::*;
#(
  parameter int              PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t [15:0] PMA_CFG         = '0,
  parameter logic [31:0]     DM_REGION_START = 32'h1A11_0800,
  parameter logic [31:0]     DM_REGION_END   = 32'h1A11_0FFF,
  parameter int              MEM_AW          = 8,
  parameter int              RESP_LATENCY    = 2,
  parameter int              MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        obi_req_i,
  output logic        obi_gnt_o,
  input  logic [31:0] obi_addr_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_wdata_i,
  input  logic [1:0]  obi_memtype_i,
  input  logic [5:0]  obi_atop_i,
  input  logic        dbg_i,
  output logic        obi_rvalid_o,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o,
  output logic        memtype_mismatch_o,
  output logic [2:0]  outstanding_o
);

  localparam int                    PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int                    CNT_W = PTR_W + 1;
  localparam logic [RESP_AGE_W-1:0] LAT   = RESP_AGE_W'(RESP_LATENCY);
  localparam int                    WORDS = 2 ** MEM_AW;

  pma_cfg_t          cfg;
  logic              override_dm;

  resp_entry_t       fifo_q [MAX_OUTSTANDING];
  resp_entry_t       head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              mismatch_q, mismatch_d;

  logic [31:0]       mem_q [WORDS];
  logic [WORDS-1:0]  valid_q;

  logic              fifo_full, fifo_empty;
  logic              accept, pop, atomic, acc_err, mem_we;
  logic [MEM_AW-1:0] word_idx;
  logic [31:0]       acc_rdata;
  logic [1:0]        memtype_exp;
  logic              unused_ok;

  uvmt_cv32e40x_pma_region_lookup #(
    .PMA_NUM_REGIONS (PMA_NUM_REGIONS),
    .PMA_CFG         (PMA_CFG),
    .DM_REGION_START (DM_REGION_START),
    .DM_REGION_END   (DM_REGION_END)
  ) u_lookup (
    .addr_i        (obi_addr_i),
    .dbg_i         (dbg_i),
    .cfg_o         (cfg),
    .override_dm_o (override_dm)
  );

  assign unused_ok = ^{cfg.main, cfg.word_addr_low, cfg.word_addr_high, obi_atop_i[4:0]};

  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);

`ifdef UVMT_CV32E40X_PMA_RESP_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d    = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  assign obi_gnt_o = !fifo_full && !lfsr_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign obi_gnt_o = !fifo_full;
`endif

  assign accept      = obi_req_i && obi_gnt_o;
  assign atomic      = obi_atop_i[5];
  assign acc_err     = !override_dm && atomic && !cfg.atomic;
  assign memtype_exp = exp_memtype(cfg, obi_we_i, atomic);
  assign word_idx    = obi_addr_i[MEM_AW+1:2];
  assign mem_we      = accept && obi_we_i && !acc_err;

  // Read data is frozen at accept so later writes cannot disturb an in-flight read.
  always_comb begin
    acc_rdata = '0;
    if (!obi_we_i && !acc_err) begin
      acc_rdata = valid_q[word_idx] ? mem_q[word_idx] : {obi_addr_i[31:2], 2'b00};
    end
  end

  assign head = fifo_q[rd_ptr_q];
  assign pop  = !fifo_empty && (head.age == LAT);

  assign obi_rvalid_o       = pop;
  assign obi_err_o          = pop && head.err;
  assign obi_rdata_o        = (pop && !head.err) ? head.rdata : '0;
  assign memtype_mismatch_o = mismatch_q;
  assign outstanding_o      = 3'(count_q);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mismatch_d = accept && (obi_memtype_i != memtype_exp);
    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mismatch_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mismatch_q <= mismatch_d;
      if (mem_we) begin
        valid_q[word_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (obi_be_i[b]) begin
          mem_q[word_idx][8*b +: 8] <= obi_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // The accept cycle itself counts toward latency, so new entries start at age 1.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (fifo_q[i].age < LAT) begin
        fifo_q[i].age <= fifo_q[i].age + 1'b1;
      end
    end
    if (accept) begin
      fifo_q[wr_ptr_q] <= '{we: obi_we_i, err: acc_err, rdata: acc_rdata, age: RESP_AGE_W'(1)};
    end
  end

endmodule

// File: tb/tb_uvmt_cv32e40x_pma_obi_responder.sv
// tb/tb_uvmt_cv32e40x_pma_obi_responder.sv - Self-checking bench with a transaction-level memory/PMA reference model.
module tb_uvmt_cv32e40x_pma_obi_responder;
  import cv32e40x_pkg::*;

  localparam int LAT  = 4;
  localparam int MAXO = 4;
  localparam int NREG = 2;
  localparam logic [31:0] DM_LO = 32'h1A11_0800;
  localparam logic [31:0] DM_HI = 32'h1A11_0FFF;

  localparam pma_cfg_t R0 = '{word_addr_low: 32'h0, word_addr_high: 32'h400, main: 1'b1,
                              bufferable: 1'b1, cacheable: 1'b1, atomic: 1'b1};
  localparam pma_cfg_t R1 = '{word_addr_low: 32'h800, word_addr_high: 32'hC00, main: 1'b1,
                              bufferable: 1'b0, cacheable: 1'b0, atomic: 1'b0};
  localparam pma_cfg_t RNONE = '0;
  localparam pma_cfg_t [15:0] CFG = {{14{RNONE}}, R1, R0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        obi_req_i = 1'b0;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i = '0;
  logic        obi_we_i = 1'b0;
  logic [3:0]  obi_be_i = '0;
  logic [31:0] obi_wdata_i = '0;
  logic [1:0]  obi_memtype_i = '0;
  logic [5:0]  obi_atop_i = '0;
  logic        dbg_i = 1'b0;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic        memtype_mismatch_o;
  logic [2:0]  outstanding_o;

  uvmt_cv32e40x_pma_obi_responder #(
    .PMA_NUM_REGIONS (NREG),
    .PMA_CFG         (CFG),
    .DM_REGION_START (DM_LO),
    .DM_REGION_END   (DM_HI),
    .MEM_AW          (8),
    .RESP_LATENCY    (LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .obi_req_i          (obi_req_i),
    .obi_gnt_o          (obi_gnt_o),
    .obi_addr_i         (obi_addr_i),
    .obi_we_i           (obi_we_i),
    .obi_be_i           (obi_be_i),
    .obi_wdata_i        (obi_wdata_i),
    .obi_memtype_i      (obi_memtype_i),
    .obi_atop_i         (obi_atop_i),
    .dbg_i              (dbg_i),
    .obi_rvalid_o       (obi_rvalid_o),
    .obi_rdata_o        (obi_rdata_o),
    .obi_err_o          (obi_err_o),
    .memtype_mismatch_o (memtype_mismatch_o),
    .outstanding_o      (outstanding_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_resp = 0;
  int          mm_seen = 0;
  int          max_out = 0;
  bit          gnt_low_seen = 0;
  rsp_t        exp_q[$];
  rsp_t        obs_q[$];
  bit          mm_exp[int];
  logic [31:0] mmem [256];
  bit          mvalid [256];

  int unsigned reg_lo [NREG] = '{32'h0000, 32'h2000};
  int unsigned reg_hi [NREG] = '{32'h1000, 32'h3000};
  bit          reg_c  [NREG] = '{1'b1, 1'b0};
  bit          reg_b  [NREG] = '{1'b1, 1'b0};
  bit          reg_a  [NREG] = '{1'b1, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  // Region attributes of an address as seen by the core, including the debug window.
  function automatic void lookup(input logic [31:0] a, input logic dbg,
                                 output bit c, output bit b, output bit at, output bit dm);
    c = 0; b = 0; at = 0;
    dm = dbg && (a >= DM_LO) && (a <= DM_HI);
    if (dm) return;
    for (int i = 0; i < NREG; i++) begin
      if (a >= reg_lo[i] && a < reg_hi[i]) begin
        c = reg_c[i]; b = reg_b[i]; at = reg_a[i];
        return;
      end
    end
  endfunction

  function automatic logic [1:0] good_memtype(input logic [31:0] a, input logic w,
                                              input logic [5:0] atop, input logic dbg);
    bit c, b, at, dm;
    lookup(a, dbg, c, b, at, dm);
    return {c, b & w & ~atop[5]};
  endfunction

  function automatic void model_accept(input logic [31:0] a, input logic w, input logic [3:0] be,
                                       input logic [31:0] wd, input logic [1:0] mt,
                                       input logic [5:0] atop, input logic dbg, input int t);
    bit c, b, at, dm, err;
    int idx;
    rsp_t r;
    lookup(a, dbg, c, b, at, dm);
    err = !dm && atop[5] && !at;
    idx = int'(a[9:2]);
    r.err = err;
    if (w || err) r.rdata = '0;
    else r.rdata = mvalid[idx] ? mmem[idx] : {a[31:2], 2'b00};
    if (w && !err) begin
      for (int k = 0; k < 4; k++) if (be[k]) mmem[idx][8*k +: 8] = wd[8*k +: 8];
      mvalid[idx] = 1;
    end
    mm_exp[t + 1] = (mt != {c, b & w & ~atop[5]});
    r.cyc = (t + LAT > last_resp) ? t + LAT : last_resp + 1;
    last_resp = r.cyc;
    exp_q.push_back(r);
  endfunction

  function automatic void model_flush();
    exp_q.delete();
    mm_exp.delete();
    for (int i = 0; i < 256; i++) mvalid[i] = 0;
    last_resp = 0;
  endfunction

  always @(negedge clk) begin : monitor
    rsp_t e;
    bit   exp_rv, exp_mm;
    if (rst_n) begin
      if (obi_req_i && !obi_gnt_o) gnt_low_seen = 1;
      if (int'(outstanding_o) > max_out) max_out = int'(outstanding_o);
      n_cmp++;
      if (outstanding_o !== 3'(exp_q.size())) begin
        n_fail++;
        $display("FAIL outstanding cyc=%0d got %0d exp %0d", cyc, outstanding_o, exp_q.size());
      end
`ifndef UVMT_CV32E40X_PMA_RESP_RANDOM_STALL_EN
      n_cmp++;
      if (obi_gnt_o !== (exp_q.size() < MAXO)) begin
        n_fail++;
        $display("FAIL grant cyc=%0d got %0b exp %0b", cyc, obi_gnt_o, exp_q.size() < MAXO);
      end
`endif
      exp_mm = mm_exp.exists(cyc) ? mm_exp[cyc] : 1'b0;
      n_cmp++;
      if (memtype_mismatch_o !== exp_mm) begin
        n_fail++;
        $display("FAIL memtype_mismatch cyc=%0d got %0b exp %0b", cyc, memtype_mismatch_o, exp_mm);
      end
      if (memtype_mismatch_o) mm_seen++;
      exp_rv = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      n_cmp++;
      if (obi_rvalid_o !== exp_rv) begin
        n_fail++;
        $display("FAIL rvalid cyc=%0d got %0b exp %0b", cyc, obi_rvalid_o, exp_rv);
      end
      if (obi_rvalid_o) obs_q.push_back('{obi_rdata_o, obi_err_o, cyc});
      if ((obi_rvalid_o || exp_rv) && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (obi_rvalid_o) begin
          n_cmp++;
          if (obi_rdata_o !== e.rdata) begin
            n_fail++;
            $display("FAIL rdata cyc=%0d got %h exp %h", cyc, obi_rdata_o, e.rdata);
          end
          n_cmp++;
          if (obi_err_o !== e.err) begin
            n_fail++;
            $display("FAIL err cyc=%0d got %0b exp %0b", cyc, obi_err_o, e.err);
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic w, input logic [3:0] be, input logic [31:0] wd,
                      input logic [1:0] mt, input logic [5:0] atop, input logic dbg, output int t);
    int waited;
    obi_addr_i = a; obi_we_i = w; obi_be_i = be; obi_wdata_i = wd;
    obi_memtype_i = mt; obi_atop_i = atop; dbg_i = dbg; obi_req_i = 1'b1;
    waited = 0;
    t = -1;
    @(negedge clk);
    while (!obi_gnt_o && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    n_cmp++;
    if (!obi_gnt_o) begin
      n_fail++;
      $display("FAIL grant_timeout addr=%h got gnt=0 exp gnt=1", a);
      obi_req_i = 1'b0;
      return;
    end
    t = cyc;
    @(posedge clk); #1;
    model_accept(a, w, be, wd, mt, atop, dbg, t);
  endtask

  task automatic idle(input int n);
    obi_req_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    obi_req_i = 1'b0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    n_cmp++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL response_timeout got %0d pending exp 0", exp_q.size());
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (obi_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %0b exp 0", obi_rvalid_o); end
    n_cmp++; if (obi_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b exp 0", obi_err_o); end
    n_cmp++; if (obi_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", obi_rdata_o); end
    n_cmp++; if (memtype_mismatch_o !== 1'b0) begin n_fail++; $display("FAIL reset_mismatch got %0b exp 0", memtype_mismatch_o); end
    n_cmp++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL reset_outstanding got %0d exp 0", outstanding_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_flush();
  endtask

  task automatic test_write_read();
    int t;
    rsp_t r;
    send(32'h100, 1'b1, 4'hF, 32'hDEADBEEF, 2'b11, 6'h0, 1'b0, t);
    send(32'h100, 1'b0, 4'hF, 32'h0, 2'b10, 6'h0, 1'b0, t);
    wait_idle();
    r = obs_q[obs_q.size()-1];
    n_cmp++; if (r.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_data got %h exp deadbeef", r.rdata); end
    n_cmp++; if (r.err !== 1'b0) begin n_fail++; $display("FAIL wr_rd_err got %0b exp 0", r.err); end
    n_cmp++; if (r.cyc - t !== LAT) begin n_fail++; $display("FAIL wr_rd_latency got %0d exp %0d", r.cyc - t, LAT); end
    r = obs_q[obs_q.size()-2];
    n_cmp++; if (r.rdata !== 32'h0) begin n_fail++; $display("FAIL write_rsp_data got %h exp 0", r.rdata); end
  endtask

  task automatic test_memtype();
    int t, base;
    base = mm_seen;
    send(32'h40, 1'b1, 4'hF, 32'hA5A5_0001, 2'b11, 6'h0, 1'b0, t);
    wait_idle();
    n_cmp++; if (mm_seen - base !== 0) begin n_fail++; $display("FAIL store_memtype got %0d pulses exp 0", mm_seen - base); end
    base = mm_seen;
    send(32'h40, 1'b0, 4'hF, 32'h0, 2'b11, 6'h0, 1'b0, t);
    wait_idle();
    n_cmp++; if (mm_seen - base !== 1) begin n_fail++; $display("FAIL load_memtype got %0d pulses exp 1", mm_seen - base); end
  endtask

  task automatic test_atomic_err();
    int t, n;
    send(32'h2000, 1'b1, 4'hF, 32'h12345678, 2'b00, 6'h00, 1'b0, t);
    send(32'h2000, 1'b1, 4'hF, 32'hFFFFFFFF, 2'b00, 6'h20, 1'b0, t);
    send(32'h2000, 1'b0, 4'hF, 32'h0, 2'b00, 6'h00, 1'b0, t);
    send(32'h1A110800, 1'b0, 4'hF, 32'h0, 2'b00, 6'h20, 1'b1, t);
    wait_idle();
    n = obs_q.size();
    n_cmp++; if (obs_q[n-3].err !== 1'b1) begin n_fail++; $display("FAIL atomic_err got %0b exp 1", obs_q[n-3].err); end
    n_cmp++; if (obs_q[n-3].rdata !== 32'h0) begin n_fail++; $display("FAIL atomic_err_rdata got %h exp 0", obs_q[n-3].rdata); end
    n_cmp++; if (obs_q[n-2].rdata !== 32'h12345678) begin n_fail++; $display("FAIL atomic_mem_kept got %h exp 12345678", obs_q[n-2].rdata); end
    n_cmp++; if (obs_q[n-1].err !== 1'b0) begin n_fail++; $display("FAIL dm_override_err got %0b exp 0", obs_q[n-1].err); end
  endtask

  task automatic test_partial();
    int t, n;
    send(32'h204, 1'b0, 4'hF, 32'h0, 2'b10, 6'h0, 1'b0, t);
    send(32'h208, 1'b1, 4'hF, 32'h11223344, 2'b11, 6'h0, 1'b0, t);
    send(32'h208, 1'b1, 4'b0010, 32'h0000AB00, 2'b11, 6'h0, 1'b0, t);
    send(32'h208, 1'b0, 4'hF, 32'h0, 2'b10, 6'h0, 1'b0, t);
    wait_idle();
    n = obs_q.size();
    n_cmp++; if (obs_q[n-4].rdata !== 32'h00000204) begin n_fail++; $display("FAIL unwritten_read got %h exp 00000204", obs_q[n-4].rdata); end
    n_cmp++; if (obs_q[n-1].rdata !== 32'h1122AB44) begin n_fail++; $display("FAIL partial_write got %h exp 1122ab44", obs_q[n-1].rdata); end
  endtask

  task automatic test_back_to_back();
    int t, base;
    base = obs_q.size();
    gnt_low_seen = 0;
    max_out = 0;
    for (int k = 0; k < 6; k++) send(32'h300 + 32'(4*k), 1'b0, 4'hF, 32'h0, 2'b10, 6'h0, 1'b0, t);
    wait_idle();
    n_cmp++; if (obs_q.size() - base !== 6) begin n_fail++; $display("FAIL b2b_count got %0d exp 6", obs_q.size() - base); end
    for (int k = 0; k < 6 && base + k < obs_q.size(); k++) begin
      n_cmp++;
      if (obs_q[base+k].rdata !== 32'h300 + 32'(4*k)) begin
        n_fail++;
        $display("FAIL b2b_order[%0d] got %h exp %h", k, obs_q[base+k].rdata, 32'h300 + 32'(4*k));
      end
    end
    n_cmp++; if (max_out !== MAXO) begin n_fail++; $display("FAIL b2b_max_outstanding got %0d exp %0d", max_out, MAXO); end
`ifndef UVMT_CV32E40X_PMA_RESP_RANDOM_STALL_EN
    n_cmp++; if (gnt_low_seen !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt_drop got %0b exp 1", gnt_low_seen); end
`endif
  endtask

  task automatic test_random();
    int t, base, sent;
    logic [31:0] a;
    logic        w, dbg;
    logic [5:0]  atop;
    logic [1:0]  mt;
    base = obs_q.size();
    sent = 0;
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0: a = 32'($urandom_range(0, 32'h3FF)) << 2;
        1: a = 32'h2000 + (32'($urandom_range(0, 32'h3FF)) << 2);
        2: a = 32'h8000 + (32'($urandom_range(0, 32'h3F)) << 2);
        default: a = DM_LO + 32'($urandom_range(0, 32'h801));
      endcase
      w    = 1'($urandom);
      dbg  = ($urandom_range(0, 3) == 0);
      atop = ($urandom_range(0, 3) == 0) ? (6'h20 | 6'($urandom_range(0, 31))) : 6'h0;
      mt   = ($urandom_range(0, 1) == 0) ? good_memtype(a, w, atop, dbg) : 2'($urandom);
      send(a, w, 4'($urandom), $urandom, mt, atop, dbg, t);
      if (t >= 0) sent++;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    wait_idle();
    n_cmp++; if (obs_q.size() - base !== sent) begin n_fail++; $display("FAIL random_count got %0d exp %0d", obs_q.size() - base, sent); end
  endtask

  task automatic test_reset_mid();
    int t, base;
    send(32'h100, 1'b0, 4'hF, 32'h0, 2'b10, 6'h0, 1'b0, t);
    send(32'h104, 1'b1, 4'hF, 32'h5555AAAA, 2'b11, 6'h0, 1'b0, t);
    send(32'h108, 1'b0, 4'hF, 32'h0, 2'b10, 6'h0, 1'b0, t);
    obi_req_i = 1'b0;
    rst_n = 1'b0;
    model_flush();
    base = obs_q.size();
    #1;
    n_cmp++; if (outstanding_o !== 3'd0) begin n_fail++; $display("FAIL midreset_outstanding got %0d exp 0", outstanding_o); end
    n_cmp++; if (obi_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL midreset_rvalid got %0b exp 0", obi_rvalid_o); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(10);
    n_cmp++; if (obs_q.size() !== base) begin n_fail++; $display("FAIL midreset_stale_rsp got %0d exp 0", obs_q.size() - base); end
    send(32'h100, 1'b0, 4'hF, 32'h0, 2'b10, 6'h0, 1'b0, t);
    n_cmp++; if (t < 0) begin n_fail++; $display("FAIL midreset_grant got %0d exp accept", t); end
    wait_idle();
    n_cmp++;
    if (obs_q.size() != base + 1 || obs_q[obs_q.size()-1].rdata !== 32'h100) begin
      n_fail++;
      $display("FAIL midreset_valid_cleared got %0d rsp exp 1 with 00000100", obs_q.size() - base);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_memtype();
    test_atomic_err();
    test_partial();
    test_back_to_back();
    test_random();
    test_reset_mid();
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uvmt_cv32e40x_pma_obi_responder.md
Name: uvmt_cv32e40x_pma_obi_responder

Overview:
- Testbench-side OBI data-bus responder. It is the memory end of the core's data interface, the counterpart to the core-side PMA predictor.
- Accepts core requests, stores write data in a small word memory and returns in-order responses after a fixed latency.
- Derives the PMA attributes each request must carry from the same region configuration the core uses, and flags mismatches on obi_memtype_i.
- Returns an error response for atomics to non-atomic regions.

Parameters:
- PMA_NUM_REGIONS, 0, number of valid entries in PMA_CFG (max 16).
- PMA_CFG, all-zero pma_cfg_t array, region table; first match wins.
- DM_REGION_START, 32'h1A11_0800, debug-module region low bound (inclusive).
- DM_REGION_END, 32'h1A11_0FFF, debug-module region high bound (inclusive).
- MEM_AW, 8, word-address bits of the internal memory (2^MEM_AW words).
- RESP_LATENCY, 2, cycles from grant to rvalid; minimum 1.
- MAX_OUTSTANDING, 4, response FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- obi_req_i  in  1  request valid
- obi_gnt_o  out  1  grant
- obi_addr_i  in  32  byte address
- obi_we_i  in  1  write enable
- obi_be_i  in  4  byte enables
- obi_wdata_i  in  32  write data
- obi_memtype_i  in  2  {cacheable, bufferable} as driven by core
- obi_atop_i  in  6  atomic op; bit 5 = atomic
- dbg_i  in  1  core in debug mode at request time
- obi_rvalid_o  out  1  response valid
- obi_rdata_o  out  32  read data
- obi_err_o  out  1  bus error
- memtype_mismatch_o  out  1  one-cycle pulse: accepted request had wrong memtype
- outstanding_o  out  3  FIFO occupancy

Behaviour:
Reset:
- All outputs 0; FIFO empty.
- Memory valid bits cleared; memory contents are not reset.

Grant:
- obi_gnt_o = !fifo_full, combinational.
- A transfer is accepted when obi_req_i && obi_gnt_o.

Attribute lookup at accept:
- Region match: low <= addr < high, using {word_addr_low, 2'b00} / {word_addr_high, 2'b00} as 34-bit compares.
- No match gives the default config: main = (PMA_NUM_REGIONS == 0), all other attributes 0.
- If dbg_i and the address is inside the DM region, the effective config is main=1 with all other attributes 0.
- Expected memtype = {cacheable, bufferable && obi_we_i && !atomic}.
- memtype_mismatch_o pulses the cycle after accept when obi_memtype_i differs from the expected value.

Error and memory access:
- err = atomic && !cfg.atomic, except the DM override always sets err = 0.
- A write without err updates the enabled bytes at mem[addr[MEM_AW+1:2]] and sets the word's valid bit.
- An erroring write does not modify memory.

FIFO entry:
- Fields: {we, err, rdata, age}.
- rdata is captured at accept. Valid word returns stored data; invalid word returns {addr[31:2], 2'b00}.
- Write responses return rdata = 0.

Response timing:
- age increments every cycle, saturating at RESP_LATENCY.
- The head entry pops when age == RESP_LATENCY, driving obi_rvalid_o plus obi_rdata_o/obi_err_o for exactly one cycle.
- At most one response per cycle; responses are strictly in order.
- An erroring response drives rdata = 0.
- Unconstrained latency: a request accepted at cycle t responds at t + RESP_LATENCY when the FIFO is not backed up.

FIFO boundaries:
- Full: gnt low; an accept and a pop in the same cycle are impossible when full.
- Pop and accept in the same cycle: occupancy unchanged.
- Pointers wrap modulo MAX_OUTSTANDING.

Same-word ordering:
- A read accepted the cycle after a write to the same word sees the new data, because the write commits at accept.

Reset mid-operation:
- Outstanding entries are discarded; no rvalid is issued for them.

Optional Feature:
- Macro: UVMT_CV32E40X_PMA_RESP_RANDOM_STALL_EN.
- Enabled: a 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11) gates grant. obi_gnt_o = !fifo_full && !lfsr[0]. The LFSR advances every cycle and resets to the seed.
- Disabled: no LFSR; grant is as specified above.

Decomposition:
- Package uvmt_cv32e40x_pma_resp_pkg:
  - resp_entry_t struct
  - expected-memtype function
  - LFSR seed/tap constants
- Reuse pma_cfg_t from cv32e40x_pkg.
- One sub-module, uvmt_cv32e40x_pma_region_lookup: combinational first-match producing effective cfg and override_dm; instantiated once.

Test Plan:
1. PMA_NUM_REGIONS=0; write 0xDEADBEEF, be=4'hF, to 0x100, then read 0x100 -> read response data 0xDEADBEEF, err=0, rvalid exactly RESP_LATENCY cycles after grant.
2. Region [0x0, 0x1000) bufferable=1, cacheable=1; store with memtype=2'b11 -> no mismatch. Load with memtype=2'b11 -> memtype_mismatch_o pulses once (expected 2'b10).
3. Region atomic=0; request with atop=6'h20 to that region -> obi_err_o=1, rdata=0, memory unchanged. Same access with dbg_i=1 to 0x1A110800 -> err=0.
4. Back-to-back requests held asserted for 6 cycles, MAX_OUTSTANDING=4, RESP_LATENCY=4 -> gnt drops after the 4th accept. outstanding_o reaches 4. Six responses arrive in order.
5. Read of never-written 0x204 -> rdata 0x00000204. Partial write be=4'b0010 data 0x0000AB00 to a word holding 0x11223344 -> readback 0x1122AB44.
6. Assert rst_n low with 3 responses pending -> no rvalid after reset release; outstanding_o=0; the next request is granted normally.
